// File: rtl/writeback_scoreboard_if.sv
// Issue, operand-collector and commit-writeback bundle for the per-slice register scoreboard.
interface writeback_scoreboard_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned DW          = 64
);
  localparam int unsigned PER_SLICE = NUM_WARPS / ISSUE_WIDTH;
  localparam int unsigned WIS_BITS  = (PER_SLICE > 1) ? $clog2(PER_SLICE) : 1;
  localparam int unsigned NR_BITS   = $clog2(NUM_REGS);

  logic [ISSUE_WIDTH-1:0]               in_valid;
  logic [ISSUE_WIDTH-1:0]               in_ready;
  logic [ISSUE_WIDTH-1:0][WIS_BITS-1:0] in_wis;
  logic [ISSUE_WIDTH-1:0]               in_wb;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  in_rd;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  in_rs1;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  in_rs2;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  in_rs3;
  logic [ISSUE_WIDTH-1:0][DW-1:0]       in_data;

  logic [ISSUE_WIDTH-1:0]               out_valid;
  logic [ISSUE_WIDTH-1:0]               out_ready;
  logic [ISSUE_WIDTH-1:0][WIS_BITS-1:0] out_wis;
  logic [ISSUE_WIDTH-1:0]               out_wb;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  out_rd;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  out_rs1;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  out_rs2;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  out_rs3;
  logic [ISSUE_WIDTH-1:0][DW-1:0]       out_data;

  logic [ISSUE_WIDTH-1:0]               wb_valid;
  logic [ISSUE_WIDTH-1:0][WIS_BITS-1:0] wb_wis;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]  wb_rd;
  logic [ISSUE_WIDTH-1:0]               wb_eop;

  // Environment side: instruction buffer, operand collector and commit stage.
  modport master (
    output in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
    output out_ready, wb_valid, wb_wis, wb_rd, wb_eop,
    input  in_ready, out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_data
  );

  // Scoreboard side.
  modport slave (
    input  in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_data,
    input  out_ready, wb_valid, wb_wis, wb_rd, wb_eop,
    output in_ready, out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_data
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// Per-issue-slice register scoreboard: blocks issue on pending operands/destination,
// clears pending registers on end-of-packet writebacks, counts hazard stall cycles.
module writeback_scoreboard #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned ISSUE_WIDTH   = 2,
  parameter int unsigned NUM_REGS      = 64,
  parameter int unsigned PERF_CTR_BITS = 44,
  parameter int unsigned DW            = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  writeback_scoreboard_if.slave    sb,
  output logic [PERF_CTR_BITS-1:0] stall_cycles
);
  localparam int unsigned PER_SLICE = NUM_WARPS / ISSUE_WIDTH;
  localparam int unsigned CNT_BITS  = $clog2(ISSUE_WIDTH + 1);

  logic [ISSUE_WIDTH-1:0][PER_SLICE-1:0][NUM_REGS-1:0] inuse_q;
  logic [ISSUE_WIDTH-1:0][PER_SLICE-1:0][NUM_REGS-1:0] inuse_d;
  logic [ISSUE_WIDTH-1:0] hazard_c;
  logic [ISSUE_WIDTH-1:0] ready_c;
  logic [ISSUE_WIDTH-1:0] fire_c;
  logic [CNT_BITS-1:0]    stall_inc_c;

  // Hazard detection, accept, and next pending bitmap (set after clear so set wins).
  always_comb begin
    hazard_c    = '0;
    ready_c     = '0;
    fire_c      = '0;
    stall_inc_c = '0;
    inuse_d     = inuse_q;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      hazard_c[s] = sb.in_valid[s] &&
                    (inuse_q[s][sb.in_wis[s]][sb.in_rs1[s]] ||
                     inuse_q[s][sb.in_wis[s]][sb.in_rs2[s]] ||
                     inuse_q[s][sb.in_wis[s]][sb.in_rs3[s]] ||
                     (sb.in_wb[s] && inuse_q[s][sb.in_wis[s]][sb.in_rd[s]]));
      ready_c[s]  = !hazard_c[s] && (!sb.out_valid[s] || sb.out_ready[s]);
      fire_c[s]   = sb.in_valid[s] && ready_c[s];
      stall_inc_c = stall_inc_c + CNT_BITS'(hazard_c[s]);
      if (sb.wb_valid[s] && sb.wb_eop[s]) begin
        inuse_d[s][sb.wb_wis[s]][sb.wb_rd[s]] = 1'b0;
      end
      if (fire_c[s] && sb.in_wb[s] && (sb.in_rd[s] != '0)) begin
        inuse_d[s][sb.in_wis[s]][sb.in_rd[s]] = 1'b1;
      end
    end
  end

  assign sb.in_ready = ready_c;

  // Pending bitmap, output-valid and stall counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_q      <= '0;
      sb.out_valid <= '0;
      stall_cycles <= '0;
    end else begin
      inuse_q      <= inuse_d;
      stall_cycles <= stall_cycles + PERF_CTR_BITS'(stall_inc_c);
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (fire_c[s]) begin
          sb.out_valid[s] <= 1'b1;
        end else if (sb.out_ready[s]) begin
          sb.out_valid[s] <= 1'b0;
        end
      end
    end
  end

  // Output payload register; loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk) begin
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      if (fire_c[s]) begin
        sb.out_wis[s]  <= sb.in_wis[s];
        sb.out_wb[s]   <= sb.in_wb[s];
        sb.out_rd[s]   <= sb.in_rd[s];
        sb.out_rs1[s]  <= sb.in_rs1[s];
        sb.out_rs2[s]  <= sb.in_rs2[s];
        sb.out_rs3[s]  <= sb.in_rs3[s];
        sb.out_data[s] <= sb.in_data[s];
      end
    end
  end

  // Flag end-of-packet writebacks that release a register that was never pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (sb.wb_valid[s] && sb.wb_eop[s] && (sb.wb_rd[s] != '0)) begin
          assert (inuse_q[s][sb.wb_wis[s]][sb.wb_rd[s]])
            else $warning("writeback_scoreboard: writeback clears a register that is not pending");
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench for writeback_scoreboard: directed scenarios plus randomized traffic
// against a pending-register model kept as plain arrays.
module tb_writeback_scoreboard;
  localparam int unsigned NUM_WARPS     = 4;
  localparam int unsigned ISSUE_WIDTH   = 2;
  localparam int unsigned NUM_REGS      = 64;
  localparam int unsigned PERF_CTR_BITS = 44;
  localparam int unsigned DW            = 64;
  localparam int unsigned PER_SLICE     = NUM_WARPS / ISSUE_WIDTH;
  localparam int unsigned WIS_BITS      = (PER_SLICE > 1) ? $clog2(PER_SLICE) : 1;
  localparam int unsigned NR_BITS       = $clog2(NUM_REGS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PERF_CTR_BITS-1:0] stall_cycles;

  always #5 clk = ~clk;

  writeback_scoreboard_if #(.NUM_WARPS(NUM_WARPS), .ISSUE_WIDTH(ISSUE_WIDTH),
                            .NUM_REGS(NUM_REGS), .DW(DW)) sb ();

  writeback_scoreboard #(.NUM_WARPS(NUM_WARPS), .ISSUE_WIDTH(ISSUE_WIDTH), .NUM_REGS(NUM_REGS),
                         .PERF_CTR_BITS(PERF_CTR_BITS), .DW(DW)) dut (
    .clk(clk), .reset(reset), .sb(sb), .stall_cycles(stall_cycles)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: set of pending (warp, reg) per slice, held instruction, stall total.
  bit                m_inuse [ISSUE_WIDTH][PER_SLICE][NUM_REGS];
  bit                m_ov    [ISSUE_WIDTH];
  logic [WIS_BITS-1:0] m_wis [ISSUE_WIDTH];
  logic              m_wb    [ISSUE_WIDTH];
  logic [NR_BITS-1:0] m_rd   [ISSUE_WIDTH];
  logic [NR_BITS-1:0] m_rs1  [ISSUE_WIDTH];
  logic [NR_BITS-1:0] m_rs2  [ISSUE_WIDTH];
  logic [NR_BITS-1:0] m_rs3  [ISSUE_WIDTH];
  logic [DW-1:0]     m_data  [ISSUE_WIDTH];
  longint unsigned   m_stall;
  bit                m_haz   [ISSUE_WIDTH];
  bit                m_rdy   [ISSUE_WIDTH];

  task automatic idle();
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      sb.in_valid[s] = 1'b0;  sb.in_wis[s] = '0;  sb.in_wb[s] = 1'b0;
      sb.in_rd[s] = '0;  sb.in_rs1[s] = '0;  sb.in_rs2[s] = '0;  sb.in_rs3[s] = '0;
      sb.in_data[s] = '0;  sb.out_ready[s] = 1'b1;
      sb.wb_valid[s] = 1'b0;  sb.wb_wis[s] = '0;  sb.wb_rd[s] = '0;  sb.wb_eop[s] = 1'b0;
    end
  endtask

  task automatic issue(input int s, input int wis, input bit wb, input int rd,
                       input int rs1, input int rs2, input int rs3);
    sb.in_valid[s] = 1'b1;
    sb.in_wis[s]   = WIS_BITS'(wis);
    sb.in_wb[s]    = wb;
    sb.in_rd[s]    = NR_BITS'(rd);
    sb.in_rs1[s]   = NR_BITS'(rs1);
    sb.in_rs2[s]   = NR_BITS'(rs2);
    sb.in_rs3[s]   = NR_BITS'(rs3);
    sb.in_data[s]  = {$urandom, $urandom};
  endtask

  task automatic wback(input int s, input int wis, input int rd, input bit eop);
    sb.wb_valid[s] = 1'b1;
    sb.wb_wis[s]   = WIS_BITS'(wis);
    sb.wb_rd[s]    = NR_BITS'(rd);
    sb.wb_eop[s]   = eop;
  endtask

  // Mid-cycle: derive the model's view of hazards and acceptance for the current inputs.
  task automatic settle();
    @(negedge clk);
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      int w = int'(sb.in_wis[s]);
      m_haz[s] = sb.in_valid[s] &&
                 (m_inuse[s][w][sb.in_rs1[s]] || m_inuse[s][w][sb.in_rs2[s]] ||
                  m_inuse[s][w][sb.in_rs3[s]] || (sb.in_wb[s] && m_inuse[s][w][sb.in_rd[s]]));
      m_rdy[s] = !m_haz[s] && (!m_ov[s] || sb.out_ready[s]);
    end
  endtask

  // Clock edge: apply the spec's update rules to the model.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        m_ov[s] = 1'b0;
        for (int w = 0; w < PER_SLICE; w++)
          for (int r = 0; r < NUM_REGS; r++) m_inuse[s][w][r] = 1'b0;
      end
      m_stall = 0;
    end else begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (m_haz[s]) m_stall++;
        if (sb.wb_valid[s] && sb.wb_eop[s]) m_inuse[s][sb.wb_wis[s]][sb.wb_rd[s]] = 1'b0;
        if (sb.in_valid[s] && m_rdy[s]) begin
          if (sb.in_wb[s] && sb.in_rd[s] != 0) m_inuse[s][sb.in_wis[s]][sb.in_rd[s]] = 1'b1;
          m_ov[s] = 1'b1;  m_wis[s] = sb.in_wis[s];  m_wb[s] = sb.in_wb[s];
          m_rd[s] = sb.in_rd[s];  m_rs1[s] = sb.in_rs1[s];  m_rs2[s] = sb.in_rs2[s];
          m_rs3[s] = sb.in_rs3[s];  m_data[s] = sb.in_data[s];
        end else if (sb.out_ready[s]) begin
          m_ov[s] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    settle(); advance();
    settle(); advance();
    reset = 1'b0;
    settle();
    tests_run++;
    if (sb.out_valid !== ISSUE_WIDTH'(0)) begin
      tests_failed++; $display("FAIL reset_out_valid got=%b want=0", sb.out_valid);
    end
    tests_run++;
    if (stall_cycles !== PERF_CTR_BITS'(0)) begin
      tests_failed++; $display("FAIL reset_stall got=%0d want=0", stall_cycles);
    end
    tests_run++;
    if (sb.in_ready !== {ISSUE_WIDTH{1'b1}}) begin
      tests_failed++; $display("FAIL reset_in_ready got=%b want=all ones", sb.in_ready);
    end
    advance();
  endtask

  task automatic test_independent();
    longint unsigned s0 = m_stall;
    for (int i = 1; i <= 8; i++) begin
      idle(); issue(0, 0, 1'b1, i, 0, 0, 0);
      settle();
      tests_run++;
      if (sb.in_ready[0] !== 1'b1) begin
        tests_failed++; $display("FAIL indep_ready i=%0d got=%b want=1", i, sb.in_ready[0]);
      end
      if (i > 1) begin
        tests_run++;
        if (sb.out_valid[0] !== 1'b1 || sb.out_rd[0] !== NR_BITS'(i - 1)) begin
          tests_failed++;
          $display("FAIL indep_out i=%0d got valid=%b rd=%0d want valid=1 rd=%0d",
                   i, sb.out_valid[0], sb.out_rd[0], i - 1);
        end
      end
      advance();
    end
    idle(); settle();
    tests_run++;
    if (sb.out_valid[0] !== 1'b1 || sb.out_rd[0] !== NR_BITS'(8)) begin
      tests_failed++;
      $display("FAIL indep_last got valid=%b rd=%0d want valid=1 rd=8", sb.out_valid[0], sb.out_rd[0]);
    end
    tests_run++;
    if (stall_cycles !== PERF_CTR_BITS'(s0)) begin
      tests_failed++; $display("FAIL indep_stall got=%0d want=%0d", stall_cycles, s0);
    end
    advance();
    // Each of rd 1..8 must now block a reader through rs1, rs2 or rs3.
    for (int k = 1; k <= 8; k++) begin
      idle();
      issue(0, 0, 1'b0, 0, (k % 3 == 0) ? k : 0, (k % 3 == 1) ? k : 0, (k % 3 == 2) ? k : 0);
      settle();
      tests_run++;
      if (sb.in_ready[0] !== 1'b0) begin
        tests_failed++; $display("FAIL indep_pending reg=%0d got ready=%b want=0", k, sb.in_ready[0]);
      end
      advance();
    end
    for (int k = 1; k <= 8; k++) begin
      idle(); wback(0, 0, k, 1'b1); settle(); advance();
    end
  endtask

  task automatic test_raw();
    longint unsigned s0;
    idle(); issue(0, 0, 1'b1, 5, 0, 0, 0);
    settle();
    tests_run++;
    if (sb.in_ready[0] !== 1'b1) begin
      tests_failed++; $display("FAIL raw_producer got ready=%b want=1", sb.in_ready[0]);
    end
    advance();
    s0 = m_stall;
    for (int c = 1; c <= 5; c++) begin
      idle(); issue(0, 0, 1'b0, 9, 5, 0, 0);
      if (c == 4) wback(0, 0, 5, 1'b1);
      settle();
      tests_run++;
      if (sb.in_ready[0] !== (c == 5)) begin
        tests_failed++; $display("FAIL raw_ready c=%0d got=%b want=%0d", c, sb.in_ready[0], c == 5);
      end
      if (c == 5) begin
        tests_run++;
        if (stall_cycles !== PERF_CTR_BITS'(s0 + 4)) begin
          tests_failed++; $display("FAIL raw_stall got=%0d want=%0d", stall_cycles, s0 + 4);
        end
      end
      advance();
    end
  endtask

  task automatic test_waw_noneop();
    idle(); issue(0, 1, 1'b1, 7, 0, 0, 0); settle(); advance();
    for (int c = 1; c <= 4; c++) begin
      idle(); issue(0, 1, 1'b1, 7, 0, 0, 0);
      if (c == 2) wback(0, 1, 7, 1'b0);
      if (c == 3) wback(0, 1, 7, 1'b1);
      settle();
      tests_run++;
      if (sb.in_ready[0] !== (c == 4)) begin
        tests_failed++; $display("FAIL waw_ready c=%0d got=%b want=%0d", c, sb.in_ready[0], c == 4);
      end
      advance();
    end
    idle(); wback(0, 1, 7, 1'b1); settle(); advance();
  endtask

  task automatic test_reg0_crosswarp();
    idle(); issue(1, 0, 1'b1, 0, 0, 0, 0); settle(); advance();
    idle(); issue(1, 0, 1'b1, 0, 0, 0, 0);
    settle();
    tests_run++;
    if (sb.in_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL reg0_ready got=%b want=1", sb.in_ready[1]);
    end
    advance();
    idle(); issue(1, 0, 1'b1, 5, 0, 0, 0); settle(); advance();
    idle(); issue(1, 1, 1'b1, 6, 5, 5, 5);
    settle();
    tests_run++;
    if (sb.in_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL crosswarp_ready got=%b want=1", sb.in_ready[1]);
    end
    advance();
    idle(); issue(1, 0, 1'b0, 0, 5, 0, 0);
    settle();
    tests_run++;
    if (sb.in_ready[1] !== 1'b0) begin
      tests_failed++; $display("FAIL samewarp_block got=%b want=0", sb.in_ready[1]);
    end
    advance();
    idle(); wback(1, 0, 5, 1'b1); settle(); advance();
    idle(); wback(1, 1, 6, 1'b1); settle(); advance();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a_data;
    longint unsigned s0;
    idle(); issue(0, 0, 1'b0, 9, 0, 0, 0);
    a_data = sb.in_data[0];
    settle(); advance();
    s0 = m_stall;
    for (int c = 1; c <= 3; c++) begin
      idle(); sb.out_ready[0] = 1'b0; issue(0, 0, 1'b0, 10, 0, 0, 0);
      settle();
      tests_run++;
      if (sb.in_ready[0] !== 1'b0) begin
        tests_failed++; $display("FAIL bp_ready c=%0d got=%b want=0", c, sb.in_ready[0]);
      end
      tests_run++;
      if (sb.out_valid[0] !== 1'b1 || sb.out_rd[0] !== NR_BITS'(9) || sb.out_data[0] !== a_data) begin
        tests_failed++;
        $display("FAIL bp_hold c=%0d got valid=%b rd=%0d data=%h want valid=1 rd=9 data=%h",
                 c, sb.out_valid[0], sb.out_rd[0], sb.out_data[0], a_data);
      end
      advance();
    end
    idle(); issue(0, 0, 1'b0, 10, 0, 0, 0);
    settle();
    tests_run++;
    if (sb.in_ready[0] !== 1'b1 || stall_cycles !== PERF_CTR_BITS'(s0)) begin
      tests_failed++;
      $display("FAIL bp_release got ready=%b stall=%0d want ready=1 stall=%0d",
               sb.in_ready[0], stall_cycles, s0);
    end
    advance();
    idle(); settle();
    tests_run++;
    if (sb.out_rd[0] !== NR_BITS'(10)) begin
      tests_failed++; $display("FAIL bp_next got rd=%0d want=10", sb.out_rd[0]);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    idle(); issue(0, 0, 1'b1, 3, 0, 0, 0); settle(); advance();
    idle(); sb.out_ready[0] = 1'b0;
    settle();
    tests_run++;
    if (sb.out_valid[0] !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_held got=%b want=1", sb.out_valid[0]);
    end
    advance();
    reset = 1'b1; idle(); settle(); advance(); reset = 1'b0;
    idle(); issue(0, 0, 1'b0, 0, 3, 0, 0);
    settle();
    tests_run++;
    if (sb.out_valid[0] !== 1'b0 || sb.in_ready[0] !== 1'b1 || stall_cycles !== PERF_CTR_BITS'(0)) begin
      tests_failed++;
      $display("FAIL rstmid_after got valid=%b ready=%b stall=%0d want valid=0 ready=1 stall=0",
               sb.out_valid[0], sb.in_ready[0], stall_cycles);
    end
    advance();
    idle(); settle();
    tests_run++;
    if (sb.out_valid[0] !== 1'b1 || sb.out_rs1[0] !== NR_BITS'(3)) begin
      tests_failed++;
      $display("FAIL rstmid_fire got valid=%b rs1=%0d want valid=1 rs1=3", sb.out_valid[0], sb.out_rs1[0]);
    end
    advance();
  endtask

  task automatic test_random();
    logic [PERF_CTR_BITS-1:0] exp_stall;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        int pend[$];
        if ($urandom_range(0, 3) != 0)
          issue(s, $urandom_range(0, PER_SLICE - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        sb.out_ready[s] = ($urandom_range(0, 3) != 0);
        for (int w = 0; w < PER_SLICE; w++)
          for (int r = 1; r < NUM_REGS; r++)
            if (m_inuse[s][w][r]) pend.push_back(w * NUM_REGS + r);
        if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
          int pick = pend[$urandom_range(0, pend.size() - 1)];
          wback(s, pick / NUM_REGS, pick % NUM_REGS, ($urandom_range(0, 3) != 0));
        end
      end
      settle();
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        tests_run++;
        if (sb.in_ready[s] !== m_rdy[s] || sb.out_valid[s] !== m_ov[s]) begin
          tests_failed++;
          $display("FAIL rand_hs cyc=%0d s=%0d got ready=%b valid=%b want ready=%b valid=%b",
                   cyc, s, sb.in_ready[s], sb.out_valid[s], m_rdy[s], m_ov[s]);
        end
        if (m_ov[s]) begin
          tests_run++;
          if ({sb.out_wis[s], sb.out_wb[s], sb.out_rd[s], sb.out_rs1[s], sb.out_rs2[s], sb.out_rs3[s],
               sb.out_data[s]} !== {m_wis[s], m_wb[s], m_rd[s], m_rs1[s], m_rs2[s], m_rs3[s], m_data[s]}) begin
            tests_failed++;
            $display("FAIL rand_payload cyc=%0d s=%0d got rd=%0d data=%h want rd=%0d data=%h",
                     cyc, s, sb.out_rd[s], sb.out_data[s], m_rd[s], m_data[s]);
          end
        end
      end
      exp_stall = m_stall[PERF_CTR_BITS-1:0];
      tests_run++;
      if (stall_cycles !== exp_stall) begin
        tests_failed++; $display("FAIL rand_stall cyc=%0d got=%0d want=%0d", cyc, stall_cycles, exp_stall);
      end
      advance();
    end
  endtask

  initial begin
    idle();
    m_stall = 0;
    test_reset();
    test_independent();
    test_raw();
    test_waw_noneop();
    test_reg0_crosswarp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
